tdm_serial_tx: RTL

- TDM serial transmitter for the MCAC serial output path: converts per-channel parallel samples into a framed, MSB-first bit stream with a frame-sync pulse.
- This is the transmit-side counterpart to the TDM serial receiver. It sits between the codec output stage, which writes channel samples, and the external serial line.
- Samples are ping-pong buffered: the writer fills the inactive bank while the active bank is shifted out. The banks swap at each frame start.

---
 rtl/mcac_tdm_pkg.sv | 14 +
 rtl/tdm_serial_tx_if.sv | 25 ++
 rtl/tdm_pingpong_buf.sv | 59 +++++
 rtl/tdm_serial_tx.sv | 92 +++++++++
 4 files changed

// File: rtl/mcac_tdm_pkg.sv
// Shared TDM constants and state type for the MCAC serial transmit and receive paths.
package mcac_tdm_pkg;
    localparam int CHANNELS = 32;
    localparam int WIDTH = 8;
    localparam logic [WIDTH-1:0] IDLE_WORD = 8'hFF;
    localparam int CH_W = $clog2(CHANNELS);
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int FRAME_BITS = CHANNELS * WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tdm_state_t;
endpackage

// File: rtl/tdm_serial_tx_if.sv
// Write port, framing controls and serial outputs of the TDM transmitter.
interface tdm_serial_tx_if;
    import mcac_tdm_pkg::*;

    logic            enable;
    logic            bit_en;
    logic            wr_en;
    logic [CH_W-1:0] wr_chan;
    logic [WIDTH-1:0] wr_data;
    logic            sdo;
    logic            fs;
    logic            frame_start;
    logic            busy;
    logic [7:0]      underrun_cnt;

    modport master (
        output enable, bit_en, wr_en, wr_chan, wr_data,
        input  sdo, fs, frame_start, busy, underrun_cnt
    );

    modport slave (
        input  enable, bit_en, wr_en, wr_chan, wr_data,
        output sdo, fs, frame_start, busy, underrun_cnt
    );
endinterface

// File: rtl/tdm_pingpong_buf.sv
// Two sample banks with per-slot valid bits; the writer always targets the bank
// that is inactive after any swap taking effect on the same edge.
module tdm_pingpong_buf
    import mcac_tdm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [CH_W-1:0]  i_wr_chan,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_swap,
    input  logic [CH_W-1:0]  i_rd_chan,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_valid
);
    logic [WIDTH-1:0]         r_data [2][CHANNELS];
    logic [1:0][CHANNELS-1:0] r_valid;
    logic                     r_sel;

    logic                     w_rd_bank;
    logic                     w_wr_bank;
    logic [1:0][CHANNELS-1:0] w_valid_nxt;

    // During a swap the read side already sees the new active bank and the
    // write side lands in the bank being retired.
    assign w_rd_bank = i_swap ? ~r_sel : r_sel;
    assign w_wr_bank = i_swap ? r_sel : ~r_sel;

    assign o_rd_data  = r_data[w_rd_bank][i_rd_chan];
    assign o_rd_valid = r_valid[w_rd_bank][i_rd_chan];

    always_comb begin
        w_valid_nxt = r_valid;
        if (i_swap) begin
            w_valid_nxt[r_sel] = '0;
        end
        if (i_wr_en) begin
            w_valid_nxt[w_wr_bank][i_wr_chan] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel   <= 1'b0;
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            if (i_swap) begin
                r_sel <= ~r_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[w_wr_bank][i_wr_chan] <= i_wr_data;
        end
    end
endmodule

// File: rtl/tdm_serial_tx.sv
// TDM serial transmitter: frames ping-pong buffered samples into an MSB-first
// bit stream with a slot-0 frame sync.
//
// state | meaning
// IDLE  | line quiet (sdo=fs=0), counters at frame origin, waiting for enable+bit_en
// RUN   | shifting slots out, one bit per bit_en
module tdm_serial_tx
    import mcac_tdm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    tdm_serial_tx_if.slave tx_if
);
    tdm_state_t       r_state;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [CH_W-1:0]  r_slot_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_sdo;
    logic             r_fs;
    logic             r_frame_start;
    logic [7:0]       r_underrun;

    logic             w_at_frame;
    logic             w_step;
    logic             w_swap;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_rd_valid;
    logic [WIDTH-1:0] w_word;

    assign w_at_frame = (r_bit_cnt == '0) && (r_slot_cnt == '0);
    // At a frame boundary only enable decides whether another frame goes out.
    assign w_step = tx_if.bit_en && (w_at_frame ? tx_if.enable : (r_state == RUN));
    assign w_swap = w_step && w_at_frame;
    assign w_word = w_rd_valid ? w_rd_data : IDLE_WORD;

    tdm_pingpong_buf u_buf (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (tx_if.wr_en),
        .i_wr_chan  (tx_if.wr_chan),
        .i_wr_data  (tx_if.wr_data),
        .i_swap     (w_swap),
        .i_rd_chan  (r_slot_cnt),
        .o_rd_data  (w_rd_data),
        .o_rd_valid (w_rd_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_slot_cnt    <= '0;
            r_shift       <= '0;
            r_sdo         <= 1'b0;
            r_fs          <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= '0;
        end else begin
            r_frame_start <= w_swap;
            if (w_step) begin
                r_state <= RUN;
                r_fs    <= w_at_frame;
                if (r_bit_cnt == '0) begin
                    r_sdo   <= w_word[WIDTH-1];
                    r_shift <= {w_word[WIDTH-2:0], 1'b0};
                    if (!w_rd_valid && (r_underrun != 8'hFF)) begin
                        r_underrun <= r_underrun + 8'd1;
                    end
                end else begin
                    r_sdo   <= r_shift[WIDTH-1];
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                end
                if (r_bit_cnt == BIT_W'(WIDTH - 1)) begin
                    r_bit_cnt  <= '0;
                    r_slot_cnt <= r_slot_cnt + 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end else if (tx_if.bit_en && (r_state == RUN)) begin
                r_state <= IDLE;
                r_sdo   <= 1'b0;
                r_fs    <= 1'b0;
            end
        end
    end

    assign tx_if.sdo          = r_sdo;
    assign tx_if.fs           = r_fs;
    assign tx_if.frame_start  = r_frame_start;
    assign tx_if.busy         = (r_state == RUN);
    assign tx_if.underrun_cnt = r_underrun;
endmodule
